pipe_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage MIPS core. Drives the PC and the
//  IF/ID, ID/EX, EX/MEM and MEM/WB register write/flush controls.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_if.sv | 50 +++++
 rtl/pipe_hazard_ctrl_hazard_compare.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   REG_AW / REG_ZERO  register-file address width and the hard-wired zero register
//   state_t + INIT/RUN/MEM_WAIT/ERR  sequencer state encoding
//   reg_hit()          source/destination match that never fires on register 0
package pipe_ctrl_pkg;

    localparam int                REG_AW   = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [1:0] state_t;

    localparam state_t INIT     = 2'd0;
    localparam state_t RUN      = 2'd1;
    localparam state_t MEM_WAIT = 2'd2;
    localparam state_t ERR      = 2'd3;

    // True when a producer register feeds the given consumer field.
    // Register 0 is constant, so writes to it can never create a dependency.
    function automatic logic reg_hit(input logic [REG_AW-1:0] prod,
                                     input logic [REG_AW-1:0] cons);
        return (prod != REG_ZERO) && (prod == cons);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the hazard controller.
// master modport: datapath side (drives ID/EX/MEM hazard info, receives controls)
// slave modport : controller side (pipe_hazard_ctrl)
// Signals:
//   id_rs, id_rt, id_uses_rt, id_branch, id_br_taken   ID-stage instruction info
//   ex_memread, ex_regwrite, ex_dst, ex_rt              EX-stage instruction info
//   mem_memread, mem_rt, mem_busy                       MEM-stage info / memory ready
//   pc_write, pc_sel_branch, ifid_write, ifid_flush,
//   idex_bubble, exmem_write, memwb_write, wdog_err     pipeline controls / status
interface pipe_hazard_ctrl_if;

    logic [pipe_ctrl_pkg::REG_AW-1:0] id_rs;
    logic [pipe_ctrl_pkg::REG_AW-1:0] id_rt;
    logic                             id_uses_rt;
    logic                             id_branch;
    logic                             id_br_taken;
    logic                             ex_memread;
    logic                             ex_regwrite;
    logic [pipe_ctrl_pkg::REG_AW-1:0] ex_dst;
    logic [pipe_ctrl_pkg::REG_AW-1:0] ex_rt;
    logic                             mem_memread;
    logic [pipe_ctrl_pkg::REG_AW-1:0] mem_rt;
    logic                             mem_busy;

    logic pc_write;
    logic pc_sel_branch;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_write;
    logic wdog_err;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_branch, id_br_taken,
               ex_memread, ex_regwrite, ex_dst, ex_rt,
               mem_memread, mem_rt, mem_busy,
        input  pc_write, pc_sel_branch, ifid_write, ifid_flush,
               idex_bubble, exmem_write, memwb_write, wdog_err
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_branch, id_br_taken,
               ex_memread, ex_regwrite, ex_dst, ex_rt,
               mem_memread, mem_rt, mem_busy,
        output pc_write, pc_sel_branch, ifid_write, ifid_flush,
               idex_bubble, exmem_write, memwb_write, wdog_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_compare.sv
// Purely combinational hazard detection.
// Inputs : ID-stage source fields/flags, EX and MEM producer info.
// Outputs: lu_o  load-use hazard (EX load feeds an ID source)
//          br_o  branch operand hazard (ID branch compares a value not yet
//                available: EX ALU result or MEM load result)
module hazard_compare
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              id_branch_i,
    input  logic              ex_memread_i,
    input  logic              ex_regwrite_i,
    input  logic [REG_AW-1:0] ex_dst_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              mem_memread_i,
    input  logic [REG_AW-1:0] mem_rt_i,
    output logic              lu_o,
    output logic              br_o
);

    logic ex_feeds_br;
    logic mem_feeds_br;

    assign lu_o = ex_memread_i &
                  (reg_hit(ex_rt_i, id_rs_i) | (id_uses_rt_i & reg_hit(ex_rt_i, id_rt_i)));

    // The branch comparator in ID reads both fields regardless of id_uses_rt.
    assign ex_feeds_br  = ex_regwrite_i &
                          (reg_hit(ex_dst_i, id_rs_i) | reg_hit(ex_dst_i, id_rt_i));
    assign mem_feeds_br = mem_memread_i &
                          (reg_hit(mem_rt_i, id_rs_i) | reg_hit(mem_rt_i, id_rt_i));

    assign br_o = id_branch_i & (ex_feeds_br | mem_feeds_br);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage MIPS core.
// Drives PC / pipeline-register enables and flushes, stalls on load-use and
// branch operand hazards, redirects the PC on a taken branch, freezes the pipe
// while data memory is busy (with watchdog) and flushes the pipe after reset.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         hazard inputs and pipeline control outputs
//   perf_stall_cnt/perf_flush_cnt  saturating counters, only when the macro
//                       HAZARD_PERF_CNT_EN is defined
// Outputs are combinational from state and inputs (zero latency).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 5,
    parameter int WDOG_LIMIT = 64,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]   perf_stall_cnt,
    output logic [CNT_W-1:0]   perf_flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave  bus
);

    // One counter serves both the INIT flush length and the MEM_WAIT watchdog.
    localparam int            CNT_MAX   = (PIPE_DEPTH > WDOG_LIMIT) ? PIPE_DEPTH : WDOG_LIMIT;
    localparam int            CB        = $clog2(CNT_MAX + 1);
    localparam logic [CB-1:0] INIT_LAST = CB'(PIPE_DEPTH - 1);
    localparam logic [CB-1:0] WDOG_LAST = CB'(WDOG_LIMIT - 1);

    state_t        state_q, state_d;
    logic [CB-1:0] cnt_q, cnt_d;
    logic [CB-1:0] cnt_inc;
    logic          lu, br;

    logic pc_write, pc_sel_branch, ifid_write, ifid_flush;
    logic idex_bubble, exmem_write, memwb_write, wdog_err;

    hazard_compare u_cmp (
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_uses_rt_i  (bus.id_uses_rt),
        .id_branch_i   (bus.id_branch),
        .ex_memread_i  (bus.ex_memread),
        .ex_regwrite_i (bus.ex_regwrite),
        .ex_dst_i      (bus.ex_dst),
        .ex_rt_i       (bus.ex_rt),
        .mem_memread_i (bus.mem_memread),
        .mem_rt_i      (bus.mem_rt),
        .lu_o          (lu),
        .br_o          (br)
    );

    assign cnt_inc = cnt_q + CB'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (bus.mem_busy) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            MEM_WAIT: begin
                // The busy cycle seen in RUN counts toward the limit, so the
                // watchdog compares the incremented value.
                if (!bus.mem_busy) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_inc == WDOG_LAST) begin
                    state_d = ERR;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_sel_branch = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_write   = 1'b0;
        memwb_write   = 1'b0;
        wdog_err      = 1'b0;
        case (state_q)
            INIT: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            // The cycle memory comes back out of MEM_WAIT behaves as RUN.
            RUN, MEM_WAIT: begin
                if (!bus.mem_busy) begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                    if (lu | br) begin
                        // A stalled branch re-resolves next cycle; no redirect now.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (bus.id_br_taken) begin
                        pc_sel_branch = 1'b1;
                        ifid_flush    = 1'b1;
                    end
                end
            end
            ERR: begin
                wdog_err = 1'b1;
            end
            default: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
        endcase
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.ifid_write    = ifid_write;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.idex_bubble   = idex_bubble;
    assign bus.exmem_write   = exmem_write;
    assign bus.memwb_write   = memwb_write;
    assign bus.wdog_err      = wdog_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign stall_ev    = ((state_q == RUN) && !bus.mem_busy && (lu | br)) ||
                         (state_q == MEM_WAIT);
    assign stall_cnt_d = sat_inc(stall_cnt_q, stall_ev);
    assign flush_cnt_d = sat_inc(flush_cnt_q, pc_sel_branch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by randomized
// traffic, all checked against a cycle-level behavioural model of the
// sequencer rules (flush countdown, busy run length, sticky error).
// Set HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_pipe_hazard_ctrl;

    localparam int PIPE_DEPTH = 5;
    localparam int WDOG_LIMIT = 64;
`ifdef HAZARD_PERF_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif

    logic clk;
    logic rst_n;

    pipe_hazard_ctrl_if bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] perf_stall_cnt;
    logic [CW-1:0] perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .WDOG_LIMIT (WDOG_LIMIT),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_init_left;
    int            m_busy_run;
    bit            m_err;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        bit lu, br, ex_hit, mem_hit;
        lu = bus.ex_memread && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        ex_hit  = bus.ex_regwrite && bus.ex_dst != 0 &&
                  (bus.ex_dst == bus.id_rs || bus.ex_dst == bus.id_rt);
        mem_hit = bus.mem_memread && bus.mem_rt != 0 &&
                  (bus.mem_rt == bus.id_rs || bus.mem_rt == bus.id_rt);
        br = bus.id_branch && (ex_hit || mem_hit);
        return lu || br;
    endfunction

    // Bit order: pc_write, pc_sel_branch, ifid_write, ifid_flush,
    //            idex_bubble, exmem_write, memwb_write, wdog_err
    function automatic logic [7:0] m_out();
        if (!rst_n || m_init_left > 0) return 8'b0001_1000;
        if (m_err)                     return 8'b0000_0001;
        if (bus.mem_busy)              return 8'b0000_0000;
        if (m_hazard())                return 8'b0000_1110;
        if (bus.id_br_taken)           return 8'b1111_0110;
        return 8'b1010_0110;
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.pc_write, bus.pc_sel_branch, bus.ifid_write, bus.ifid_flush,
                bus.idex_bubble, bus.exmem_write, bus.memwb_write, bus.wdog_err};
    endfunction

    task automatic m_reset();
        m_init_left = PIPE_DEPTH;
        m_busy_run  = 0;
        m_err       = 0;
        m_stall     = '0;
        m_flush     = '0;
    endtask

    task automatic m_advance();
        if (!rst_n) return;
        if (m_init_left == 0 && !m_err) begin
            if ((m_busy_run > 0 || (!bus.mem_busy && m_hazard())) && m_stall != '1)
                m_stall = m_stall + 1'b1;
            if (!bus.mem_busy && !m_hazard() && bus.id_br_taken && m_flush != '1)
                m_flush = m_flush + 1'b1;
        end
        if (m_init_left > 0) m_init_left--;
        else if (m_err) ;
        else if (bus.mem_busy) begin
            m_busy_run++;
            if (m_busy_run == WDOG_LIMIT) m_err = 1;
        end else m_busy_run = 0;
    endtask

    task automatic idle();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.id_branch = 0;
        bus.id_br_taken = 0; bus.ex_memread = 0; bus.ex_regwrite = 0;
        bus.ex_dst = 0; bus.ex_rt = 0; bus.mem_memread = 0; bus.mem_rt = 0;
        bus.mem_busy = 0;
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic step(input string tag, output logic [7:0] got);
        if (!rst_n) m_reset();
        #3;
        got = dut_out();
        check_eq(tag, {24'd0, got}, {24'd0, m_out()});
`ifdef HAZARD_PERF_CNT_EN
        check_eq({tag, "_pstall"}, 32'(perf_stall_cnt), 32'(m_stall));
        check_eq({tag, "_pflush"}, 32'(perf_flush_cnt), 32'(m_flush));
`endif
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [7:0] g;
        rst_n = 1'b0;
        idle();
        step("reset", g);
        check_eq("reset_flush", 32'(g[4]), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < PIPE_DEPTH; i++) step("init", g);
    endtask

    logic [7:0] g;
    int busy_left;

    initial begin
        rst_n = 1'b0;
        idle();
        m_reset();
        @(posedge clk);
        #1;
        step("reset0", g);
        check_eq("reset0_pcw", 32'(g[7]), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            step("init", g);
            check_eq("init_flush", 32'(g[4]), 32'd1);
            check_eq("init_pcw", 32'(g[7]), 32'd0);
        end
        step("run_first", g);
        check_eq("run_first_pcw", 32'(g[7]), 32'd1);

        // Load-use on rs
        bus.ex_memread = 1; bus.ex_rt = 3; bus.id_rs = 3;
        step("lu", g);
        check_eq("lu_pcw", 32'(g[7]), 32'd0);
        check_eq("lu_bubble", 32'(g[3]), 32'd1);
        idle();
        step("lu_after", g);
        check_eq("lu_after_pcw", 32'(g[7]), 32'd1);

        // Register zero never hazards
        bus.ex_memread = 1; bus.ex_rt = 0; bus.id_rs = 0;
        step("lu_r0", g);
        check_eq("lu_r0_pcw", 32'(g[7]), 32'd1);

        // Branch operand hazard, then redirect
        idle();
        bus.id_branch = 1; bus.id_br_taken = 1; bus.ex_regwrite = 1;
        bus.ex_dst = 7; bus.id_rt = 7;
        step("br_stall", g);
        check_eq("br_stall_sel", 32'(g[6]), 32'd0);
        check_eq("br_stall_pcw", 32'(g[7]), 32'd0);
        bus.ex_regwrite = 0;
        step("br_taken", g);
        check_eq("br_taken_sel", 32'(g[6]), 32'd1);
        check_eq("br_taken_flush", 32'(g[4]), 32'd1);

        // Short memory stall
        idle();
        bus.mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            step("busy3", g);
            check_eq("busy3_writes", 32'({g[7], g[5], g[2], g[1]}), 32'd0);
        end
        bus.mem_busy = 0;
        step("busy3_exit", g);
        check_eq("busy3_exit_pcw", 32'(g[7]), 32'd1);
        check_eq("busy3_exit_err", 32'(g[0]), 32'd0);

        // One below the watchdog limit
        bus.mem_busy = 1;
        for (int i = 0; i < WDOG_LIMIT - 1; i++) step("busy63", g);
        bus.mem_busy = 0;
        step("busy63_exit", g);
        check_eq("busy63_err", 32'(g[0]), 32'd0);
        check_eq("busy63_pcw", 32'(g[7]), 32'd1);

        // Watchdog timeout
        bus.mem_busy = 1;
        for (int i = 0; i < WDOG_LIMIT; i++) step("busy64", g);
        bus.mem_busy = 0;
        step("wdog", g);
        check_eq("wdog_err", 32'(g[0]), 32'd1);
        check_eq("wdog_freeze", 32'(g[7]), 32'd0);
        step("wdog_hold", g);
        check_eq("wdog_hold_err", 32'(g[0]), 32'd1);
        rst_n = 1'b0;
        step("wdog_rst", g);
        check_eq("wdog_rst_err", 32'(g[0]), 32'd0);
        check_eq("wdog_rst_flush", 32'(g[4]), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < PIPE_DEPTH; i++) step("reinit", g);

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bus.ex_memread = 1; bus.ex_rt = 4; bus.id_rt = 4; bus.id_uses_rt = 1;
            step("perf_lu", g);
            idle();
            step("perf_idle", g);
        end
        bus.id_branch = 1; bus.id_br_taken = 1;
        step("perf_br", g);
        idle();
        check_eq("perf_stall2", 32'(perf_stall_cnt), 32'd2);
        check_eq("perf_flush1", 32'(perf_flush_cnt), 32'd1);
        bus.ex_memread = 1; bus.ex_rt = 9; bus.id_rs = 9;
        for (int i = 0; i < 20; i++) step("perf_sat", g);
        idle();
        check_eq("perf_stall_sat", 32'(perf_stall_cnt), 32'(2 ** CW - 1));
`endif

        // Randomized traffic with bursty memory stalls and occasional resets
        busy_left = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.id_rs       = 5'($urandom_range(0, 3));
            bus.id_rt       = 5'($urandom_range(0, 3));
            bus.id_uses_rt  = 1'($urandom_range(0, 1));
            bus.id_branch   = ($urandom_range(0, 3) == 0);
            bus.id_br_taken = 1'($urandom_range(0, 1));
            bus.ex_memread  = ($urandom_range(0, 3) == 0);
            bus.ex_regwrite = 1'($urandom_range(0, 1));
            bus.ex_dst      = 5'($urandom_range(0, 3));
            bus.ex_rt       = 5'($urandom_range(0, 3));
            bus.mem_memread = ($urandom_range(0, 3) == 0);
            bus.mem_rt      = 5'($urandom_range(0, 3));
            if (busy_left > 0) busy_left--;
            else if ($urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 70);
            bus.mem_busy = (busy_left > 0);
            rst_n = ($urandom_range(0, 399) != 0);
            step("rand", g);
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
